// File: rtl/booth_acc_pkg.sv
// Shared constants and FSM encoding for the Booth product accumulator.
package booth_acc_pkg;

    localparam int unsigned PRODUCT_WIDTH = 16;
    localparam int unsigned COUNT_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_add_module.sv
// Combinational accumulate step: acc + sign-extended product, with optional clamp.
// ACC_SATURATE_EN selects saturating arithmetic; otherwise the sum wraps and ovf_c is 0.
module sat_add_module
    import booth_acc_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic [ACC_WIDTH-1:0]     acc_i,
    input  logic [PRODUCT_WIDTH-1:0] addend_i,
    output logic [ACC_WIDTH-1:0]     sum_c,
    output logic                     ovf_c
);

`ifdef ACC_SATURATE_EN
    localparam int unsigned EXT_W = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] addend_ext;
    logic [EXT_W-1:0] sum_ext;
    logic             ovf;

    assign acc_ext    = EXT_W'($signed(acc_i));
    assign addend_ext = EXT_W'($signed(addend_i));
    assign sum_ext    = acc_ext + addend_ext;

    // Equal operand signs with a flipped result sign shows up as MSB pair disagreement.
    assign ovf   = sum_ext[EXT_W-1] ^ sum_ext[EXT_W-2];
    assign sum_c = ovf ? (sum_ext[EXT_W-1] ? SAT_MIN : SAT_MAX) : sum_ext[ACC_WIDTH-1:0];
    assign ovf_c = ovf;
`else
    assign sum_c = acc_i + ACC_WIDTH'($signed(addend_i));
    assign ovf_c = 1'b0;
`endif

endmodule

// File: rtl/booth_product_accumulator_module.sv
// Sums COUNT_N signed Booth products per window and returns the total over valid/ready.
// Build option: ACC_SATURATE_EN (saturating accumulator with sticky Overflow_Flag).
module booth_product_accumulator_module
    import booth_acc_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned COUNT_N   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start_Sig,
    input  logic [PRODUCT_WIDTH-1:0] Product_In,
    input  logic                     Product_Valid,
    output logic                     Product_Ready,
    output logic [ACC_WIDTH-1:0]     Sum_Out,
    output logic                     Sum_Valid,
    input  logic                     Sum_Ready,
    output logic                     Busy,
    output logic                     Overflow_Flag
);

    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(COUNT_N - 1);

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   flag_q, flag_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    logic                   accept;
    logic [ACC_WIDTH-1:0]   add_sum;
    logic                   add_ovf;

    sat_add_module #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .acc_i    (acc_q),
        .addend_i (Product_In),
        .sum_c    (add_sum),
        .ovf_c    (add_ovf)
    );

    assign accept = Product_Valid && ready_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;

        case (state_q)
            ST_IDLE: begin
                if (Start_Sig) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d  = add_sum;
                    cnt_d  = cnt_q + COUNT_WIDTH'(1);
                    flag_d = flag_q | add_ovf;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (Sum_Ready) begin
                    if (Start_Sig) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        flag_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_ACCUM);
        valid_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign Product_Ready = ready_q;
    assign Sum_Out       = acc_q;
    assign Sum_Valid     = valid_q;
    assign Busy          = busy_q;
    assign Overflow_Flag = flag_q;

endmodule
